// File: rtl/psel_pkg.sv
// Shared definitions for the multi-grant round-robin priority selector.
package psel_pkg;

    // Pointer update policies
    localparam int PSEL_MODE_INC = 0;  // advance by one on every enabled cycle
    localparam int PSEL_MODE_RR  = 1;  // advance past the last granted requester

    // Grant-lock state
    typedef enum logic {
        PSEL_UNLOCKED = 1'b0,
        PSEL_LOCKED   = 1'b1
    } psel_lock_e;

endpackage

// File: rtl/psel_rot_find.sv
// Rotated first-one finder: returns the first requester at or after ptr
// (wrapping modulo WIDTH) that is requesting and not masked out.
module psel_rot_find import psel_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         req,
    input  logic [WIDTH-1:0]         mask,
    input  logic [$clog2(WIDTH)-1:0] ptr,
    output logic [WIDTH-1:0]         onehot,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     valid
);

    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] cand;

    assign cand = req & ~mask;

    // Walk the requesters in priority order starting at ptr; first hit wins
    always_comb begin
        int p;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        p      = 0;
        for (int i = 0; i < WIDTH; i++) begin
            p = int'(ptr) + i;
            if (p >= WIDTH) begin
                p = p - WIDTH;
            end
            if (!valid && cand[p]) begin
                valid     = 1'b1;
                onehot[p] = 1'b1;
                idx       = IW'(p);
            end
        end
    end

endmodule

// File: rtl/psel_rr_multi.sv
// Multi-grant round-robin priority selector with optional slot-0 grant lock.
// Grants are combinational from req/en and the registered pointer/lock state.
module psel_rr_multi import psel_pkg::*; #(
    parameter int WIDTH   = 16,
    parameter int NUM_GNT = 2,
    parameter int MODE    = PSEL_MODE_RR,
    parameter int LOCK_EN = 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [WIDTH-1:0]                       req,
    input  logic [WIDTH-1:0]                       lock,
    input  logic                                   en,
    output logic [WIDTH-1:0]                       gnt,
    output logic [NUM_GNT-1:0][WIDTH-1:0]          gnt_bus,
    output logic [NUM_GNT-1:0][$clog2(WIDTH)-1:0]  gnt_idx,
    output logic [NUM_GNT-1:0]                     gnt_valid,
    output logic [$clog2(WIDTH)-1:0]               count,
    output logic                                   locked
);

    localparam int              IW   = $clog2(WIDTH);
    localparam logic [IW-1:0]   LAST = IW'(WIDTH - 1);

    // Pointer increment that wraps at WIDTH, not at 2**IW
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == LAST) ? '0 : v + 1'b1;
    endfunction

    psel_lock_e       lstate;
    logic [IW-1:0]    owner;
    logic [WIDTH-1:0] req_eff;
    logic [WIDTH-1:0] owner_oh;
    logic             hold_c;
    logic             acq_c;
    logic             rel_c;
    logic [IW-1:0]    last_idx;

    assign locked   = (lstate == PSEL_LOCKED);
    // Disabled or in reset: nothing is visible to the finders, so every grant output is 0
    assign req_eff  = (en && !reset) ? req : '0;
    assign owner_oh = WIDTH'(1) << owner;
    // Owner keeps slot 0 only while it is still requesting
    assign hold_c   = (LOCK_EN != 0) && locked && req_eff[owner];
    assign acq_c    = (LOCK_EN != 0) && !locked && gnt_valid[0] && lock[gnt_idx[0]];
    assign rel_c    = locked && en && (!req[owner] || !lock[owner]);

    // Slot chain: each slot excludes everything granted by the slots above it
    for (genvar k = 0; k < NUM_GNT; k++) begin : g_slot
        logic [WIDTH-1:0] m_in;
        logic [WIDTH-1:0] m_out;
        logic [WIDTH-1:0] s_oh;
        logic [IW-1:0]    s_idx;
        logic             s_vld;
        logic [WIDTH-1:0] f_oh;
        logic [IW-1:0]    f_idx;
        logic             f_vld;

        psel_rot_find #(.WIDTH(WIDTH)) u_find (
            .req    (req_eff),
            .mask   (m_in),
            .ptr    (count),
            .onehot (f_oh),
            .idx    (f_idx),
            .valid  (f_vld)
        );

        if (k == 0) begin : g_head
            assign m_in  = '0;
            assign s_oh  = hold_c ? owner_oh : f_oh;
            assign s_idx = hold_c ? owner : f_idx;
            assign s_vld = hold_c | f_vld;
        end else begin : g_tail
            assign m_in  = g_slot[k-1].m_out;
            assign s_oh  = f_oh;
            assign s_idx = f_idx;
            assign s_vld = f_vld;
        end

        assign m_out        = m_in | s_oh;
        assign gnt_bus[k]   = s_oh;
        assign gnt_idx[k]   = s_idx;
        assign gnt_valid[k] = s_vld;
    end

    // Merged grant vector and index of the lowest-priority valid slot
    always_comb begin
        gnt      = '0;
        last_idx = '0;
        for (int k = 0; k < NUM_GNT; k++) begin
            gnt = gnt | gnt_bus[k];
            if (gnt_valid[k]) begin
                last_idx = gnt_idx[k];
            end
        end
    end

    // Lock FSM: capture the slot-0 owner, release when it stops requesting or locking
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lstate <= PSEL_UNLOCKED;
            owner  <= '0;
        end else if (acq_c) begin
            lstate <= PSEL_LOCKED;
            owner  <= gnt_idx[0];
        end else if (rel_c) begin
            lstate <= PSEL_UNLOCKED;
        end
    end

    // Priority pointer; frozen from the acquiring edge through the release edge
    // so the pointer resumes where it stood before the lock was taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en && !locked && !acq_c) begin
            if (MODE == PSEL_MODE_INC) begin
                count <= wrap_inc(count);
            end else if (gnt_valid[0]) begin
                count <= wrap_inc(last_idx);
            end
        end
    end

endmodule

// File: tb/tb_psel_rr_multi.sv
// Directed bench for psel_rr_multi: one MODE 1 and one MODE 0 instance,
// WIDTH=8, NUM_GNT=2, hand-computed expectations.
module tb_psel_rr_multi;

    logic clock;
    logic reset;

    logic [7:0]      req_r, lock_r, gnt_r;
    logic            en_r, lk_r;
    logic [1:0][7:0] bus_r;
    logic [1:0][2:0] idx_r;
    logic [1:0]      vld_r;
    logic [2:0]      cnt_r;

    logic [7:0]      req_i, lock_i, gnt_i;
    logic            en_i, lk_i;
    logic [1:0][7:0] bus_i;
    logic [1:0][2:0] idx_i;
    logic [1:0]      vld_i;
    logic [2:0]      cnt_i;

    int checks = 0;
    int errors = 0;

    psel_rr_multi #(.WIDTH(8), .NUM_GNT(2), .MODE(1), .LOCK_EN(1)) dut_rr (
        .clock(clock), .reset(reset), .req(req_r), .lock(lock_r), .en(en_r),
        .gnt(gnt_r), .gnt_bus(bus_r), .gnt_idx(idx_r), .gnt_valid(vld_r),
        .count(cnt_r), .locked(lk_r)
    );

    psel_rr_multi #(.WIDTH(8), .NUM_GNT(2), .MODE(0), .LOCK_EN(1)) dut_inc (
        .clock(clock), .reset(reset), .req(req_i), .lock(lock_i), .en(en_i),
        .gnt(gnt_i), .gnt_bus(bus_i), .gnt_idx(idx_i), .gnt_valid(vld_i),
        .count(cnt_i), .locked(lk_i)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check both slots of the MODE 1 instance
    task automatic chk_rr(input string tag, input logic [2:0] i0, input logic [2:0] i1,
                          input logic [1:0] v, input logic [7:0] g);
        chk({tag, "_idx0"}, idx_r[0], i0);
        chk({tag, "_idx1"}, idx_r[1], i1);
        chk({tag, "_vld"},  vld_r, v);
        chk({tag, "_gnt"},  gnt_r, g);
    endtask

    initial begin
        reset  = 1'b1;
        req_r  = 8'hFF; lock_r = 8'h00; en_r = 1'b1;
        req_i  = 8'h00; lock_i = 8'h00; en_i = 1'b0;
        #2;
        // Reset holds all grants at zero even with every requester asserted
        chk_rr("rst", 3'd0, 3'd0, 2'b00, 8'h00);
        chk("rst_cnt", cnt_r, 3'd0);
        chk("rst_lk", lk_r, 1'b0);
        tick();
        chk("rst_edge_gnt", gnt_r, 8'h00);
        reset = 1'b0;
        #1;

        // MODE 1 sweep with all requesters: pairs advance by two
        chk_rr("rr_a", 3'd0, 3'd1, 2'b11, 8'h03);
        chk("rr_a_bus1", bus_r[1], 8'h02);
        tick(); chk("rr_cnt2", cnt_r, 3'd2);
        chk_rr("rr_b", 3'd2, 3'd3, 2'b11, 8'h0C);
        tick(); chk("rr_cnt4", cnt_r, 3'd4);
        chk_rr("rr_c", 3'd4, 3'd5, 2'b11, 8'h30);
        tick(); chk("rr_cnt6", cnt_r, 3'd6);
        chk_rr("rr_d", 3'd6, 3'd7, 2'b11, 8'hC0);
        tick(); chk("rr_cnt_wrap", cnt_r, 3'd0);

        // Bring pointer to 6 for the wrap case
        tick(); tick(); tick();
        chk("wrap_cnt6", cnt_r, 3'd6);
        req_r = 8'b0100_0001; #1;
        chk_rr("wrap", 3'd6, 3'd0, 2'b11, 8'h41);
        chk("wrap_bus0", bus_r[0], 8'h40);
        tick(); chk("wrap_cnt1", cnt_r, 3'd1);
        req_r = 8'h01; #1;
        chk_rr("single", 3'd0, 3'd0, 2'b01, 8'h01);
        chk("single_bus1", bus_r[1], 8'h00);
        tick(); chk("single_cnt", cnt_r, 3'd1);

        // Move pointer to 3
        req_r = 8'h04; #1;
        tick(); chk("pre_lock_cnt", cnt_r, 3'd3);

        // Lock acquisition by requester 3
        req_r = 8'h08; lock_r = 8'h08; #1;
        chk_rr("lk_acq", 3'd3, 3'd0, 2'b01, 8'h08);
        chk("lk_acq_pre", lk_r, 1'b0);
        tick();
        chk("lk_acq_lk", lk_r, 1'b1);
        chk("lk_acq_cnt", cnt_r, 3'd3);
        req_r = 8'hFF; #1;
        for (int c = 0; c < 3; c++) begin
            chk_rr("lk_hold", 3'd3, 3'd4, 2'b11, 8'h18);
            tick();
            chk("lk_hold_cnt", cnt_r, 3'd3);
            chk("lk_hold_lk", lk_r, 1'b1);
        end
        // Release cycle: owner still in slot 0, pointer frozen
        lock_r = 8'h00; #1;
        chk_rr("lk_rel", 3'd3, 3'd4, 2'b11, 8'h18);
        tick();
        chk("lk_rel_lk", lk_r, 1'b0);
        chk("lk_rel_cnt", cnt_r, 3'd3);
        chk_rr("post_rel", 3'd3, 3'd4, 2'b11, 8'h18);
        tick(); chk("post_rel_cnt", cnt_r, 3'd5);

        // Disable: no grants, state holds
        en_r = 1'b0; #1;
        chk_rr("dis", 3'd0, 3'd0, 2'b00, 8'h00);
        tick();
        chk("dis_cnt", cnt_r, 3'd5);
        chk("dis_lk", lk_r, 1'b0);
        en_r = 1'b1; req_r = 8'h00; #1;
        chk_rr("noreq", 3'd0, 3'd0, 2'b00, 8'h00);
        tick(); chk("noreq_cnt", cnt_r, 3'd5);

        // Relock on requester 3 with pointer at 5
        req_r = 8'h08; lock_r = 8'h08; #1;
        tick();
        chk("relock_lk", lk_r, 1'b1);
        chk("relock_cnt", cnt_r, 3'd5);
        en_r = 1'b0; req_r = 8'hFF; #1;
        chk("dis_lk_gnt", gnt_r, 8'h00);
        tick();
        chk("dis_lk_lk", lk_r, 1'b1);
        chk("dis_lk_cnt", cnt_r, 3'd5);
        en_r = 1'b1; #1;
        chk_rr("lk5", 3'd3, 3'd5, 2'b11, 8'h28);

        // Asynchronous reset in the middle of a cycle while locked
        #1; reset = 1'b1; #1;
        chk_rr("arst", 3'd0, 3'd0, 2'b00, 8'h00);
        chk("arst_cnt", cnt_r, 3'd0);
        chk("arst_lk", lk_r, 1'b0);
        tick();
        reset = 1'b0; lock_r = 8'h00; #1;
        chk_rr("after_rst", 3'd0, 3'd1, 2'b11, 8'h03);
        tick(); chk("after_rst_cnt", cnt_r, 3'd2);

        // MODE 0: pointer advances by one regardless of grants
        en_r = 1'b0;
        req_i = 8'h81; en_i = 1'b1; #1;
        chk("inc_c0_cnt", cnt_i, 3'd0);
        chk("inc_c0_idx0", idx_i[0], 3'd0);
        chk("inc_c0_idx1", idx_i[1], 3'd7);
        chk("inc_c0_gnt", gnt_i, 8'h81);
        tick(); chk("inc_cnt1", cnt_i, 3'd1);
        chk("inc_c1_idx0", idx_i[0], 3'd7);
        chk("inc_c1_idx1", idx_i[1], 3'd0);
        tick(); chk("inc_cnt2", cnt_i, 3'd2);
        chk("inc_c2_idx0", idx_i[0], 3'd7);
        chk("inc_c2_idx1", idx_i[1], 3'd0);
        chk("inc_c2_vld", vld_i, 2'b11);
        tick(); chk("inc_cnt3", cnt_i, 3'd3);
        chk("rr_idle_cnt", cnt_r, 3'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psel_rr_multi.md
Name: psel_rr_multi

Overview:
- Parametrised round-robin priority selector; successor to the single-grant rotating selector.
- Issues up to NUM_GNT grants per cycle from WIDTH requesters, ordered by a rotating priority pointer.
- Two pointer-update modes: legacy advance-by-one, or advance past the last granted requester (true RR).
- Optional grant lock lets a requester hold slot 0 across multiple cycles.
- Used by issue/dispatch and CDB arbitration paths.

Parameters:
- WIDTH, 16, number of requesters (any value >= 2; need not be a power of two).
- NUM_GNT, 2, maximum grants per cycle (1..WIDTH).
- MODE, 1, pointer update: 0 = increment by 1 on every enabled cycle; 1 = move to last granted index + 1.
- LOCK_EN, 1, 1 = lock input honoured; 0 = lock ignored and lock logic removed.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  WIDTH  request vector.
- lock  in  WIDTH  per-requester hold request; meaningful only while that requester is granted in slot 0.
- en  in  1  arbitration enable.
- gnt  out  WIDTH  OR of all slot grants; at most NUM_GNT bits set.
- gnt_bus  out  NUM_GNT x WIDTH  per-slot one-hot grant; slot 0 has highest priority.
- gnt_idx  out  NUM_GNT x $clog2(WIDTH)  per-slot granted index; 0 when the slot is invalid.
- gnt_valid  out  NUM_GNT  per-slot grant valid.
- count  out  $clog2(WIDTH)  current priority pointer.
- locked  out  1  lock currently held.

Behaviour:
- Grants are combinational from req/en and the registered state: 0-cycle latency. State updates on the rising clock edge.
- Priority order: count, count+1, ..., WIDTH-1, 0, ..., count-1 (wraps modulo WIDTH, not modulo 2^n).
- Slot k receives the (k+1)-th highest-priority asserted request. Slots fill contiguously from 0, so gnt_valid is always of the form 0..01..1.
- Fewer requests than NUM_GNT: the upper slots are invalid (gnt_bus 0, gnt_idx 0, gnt_valid 0).
- en=0: all grant outputs are 0; count, locked and lock owner hold their values.
- MODE 0: on en, count <= (count==WIDTH-1) ? 0 : count+1, regardless of req.
- MODE 1: on en with at least one grant, count <= (highest valid slot's idx + 1) mod WIDTH. On en with no grant, count holds.
- Lock (LOCK_EN=1) is a 2-state FSM, UNLOCKED/LOCKED:
  - UNLOCKED -> LOCKED when en, slot 0 is valid, and lock[gnt_idx[0]]=1. The owner register captures gnt_idx[0].
  - While LOCKED and en: if req[owner]=1, slot 0 is forced to owner and the remaining slots arbitrate over the other requesters in normal pointer order.
  - LOCKED -> UNLOCKED at the edge where en=1 and (req[owner]=0 or lock[owner]=0). If req[owner]=0, slot 0 arbitrates normally that same cycle.
  - count is frozen while LOCKED in both modes, including the release cycle.
- Reset asserted (async): count=0, state UNLOCKED, owner=0, locked=0. All grant outputs are forced to 0 while reset is high, irrespective of req.
- Reset during a lock: the lock is dropped immediately. After deassertion, arbitration restarts from pointer 0.
- NUM_GNT >= popcount(req): every requester is granted that cycle.
- Simultaneous events: a requester never appears in two slots, and gnt equals the OR of the gnt_bus rows.

Decomposition:
- Shared package psel_pkg holds:
  - localparams PSEL_MODE_INC=0 and PSEL_MODE_RR=1;
  - the lock state enum typedef (PSEL_UNLOCKED, PSEL_LOCKED).
- One sub-module, psel_rot_find: combinational rotated first-one finder with inputs req, mask, ptr and outputs onehot, idx, valid.
  - Instantiated NUM_GNT times in a generate chain.
  - Each stage masks out all requesters granted by earlier stages (and the lock owner).
- No other hierarchy.

Test Plan:
All scenarios use WIDTH=8, NUM_GNT=2.
- MODE1, after reset, req=8'hFF, en=1 held 4 cycles -> slot pairs (0,1),(2,3),(4,5),(6,7); count sequence 0,2,4,6, then wraps to 0.
- Wrap: count=6, req=8'b0100_0001 -> slot0 idx 6, slot1 idx 0, gnt=8'h41; next count=1. Then req=8'h01 -> only slot0 valid (idx 0); count=1.
- MODE0: req=8'h81 for 3 cycles from count=0 -> grants (0,7),(7,0),(7,0); count 0->1->2->3 independent of the grants.
- Lock: count=3, req=8'h08, lock=8'h08 -> slot0=3, locked=1. Then req=8'hFF for 3 cycles -> slot0=3 each cycle, slot1=4, count stays 3. Drop lock -> locked=0 next edge; the following cycle grants (3,4) and count becomes 5.
- en=0 with req=8'hFF -> gnt=0, gnt_valid=0, count and locked unchanged. Then en=1, req=0 in MODE1 -> no grants, count unchanged.
- Assert reset asynchronously mid-cycle while locked with count=5 -> outputs zero immediately; count=0 and locked=0 before the next clock edge. After release, req=8'hFF -> grants (0,1).
